// File: rtl/hp_sprite_blitter.sv
// hp_sprite_blitter: raster-scans a sprite ROM and writes its opaque, on-screen pixels to a framebuffer.
module hp_sprite_blitter #(
  parameter int SPR_W  = 12,
  parameter int SPR_H  = 16,
  parameter int FB_W   = 320,
  parameter int FB_H   = 240,
  parameter int TRANSP = 0
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  input  logic        flip_h,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rom_address,
  input  logic [1:0]  rom_q,
  output logic        fb_we,
  output logic [16:0] fb_addr,
  output logic [1:0]  fb_data
);
  localparam int CW = $clog2(SPR_W);
  localparam int RW = $clog2(SPR_H);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] col_q, col_d, rcol;
  logic [RW-1:0] row_q, row_d;
  logic [9:0] px_q, px_d, py_q, py_d;
  logic flip_q, flip_d, drain_q, drain_d, last_col, last_row;
  logic v1_q, v1_d, we_q, we_d;
  logic [10:0] sx1_q, sx1_d, sy1_q, sy1_d;
  logic [16:0] addr_q, addr_d;
  logic [1:0] data_q, data_d;
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      px_q    <= '0;
      py_q    <= '0;
      flip_q  <= 1'b0;
      drain_q <= 1'b0;
      v1_q    <= 1'b0;
      sx1_q   <= '0;
      sy1_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      px_q    <= px_d;
      py_q    <= py_d;
      flip_q  <= flip_d;
      drain_q <= drain_d;
      v1_q    <= v1_d;
      sx1_q   <= sx1_d;
      sy1_q   <= sy1_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    px_d     = px_q;
    py_d     = py_q;
    flip_d   = flip_q;
    drain_d  = drain_q;
    last_col = col_q == CW'(SPR_W - 1);
    last_row = row_q == RW'(SPR_H - 1);
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        px_d    = pos_x;
        py_d    = pos_y;
        flip_d  = flip_h;
        col_d   = '0;
        row_d   = '0;
      end
      RUN: begin
        col_d   = last_col ? '0 : col_q + 1'b1;
        row_d   = last_col ? (last_row ? '0 : row_q + 1'b1) : row_q;
        drain_d = 1'b0;
        state_d = (last_col && last_row) ? DRAIN : RUN;
      end
      DRAIN: begin
        drain_d = 1'b1;
        state_d = drain_q ? DONE : DRAIN;
      end
      DONE: state_d = IDLE;
    endcase
    // stage 1 travels with the ROM read; stage 2 sees rom_q and decides the write
    rcol   = flip_q ? CW'(SPR_W - 1) - col_q : col_q;
    v1_d   = state_q == RUN;
    sx1_d  = 11'(px_q) + 11'(col_q);
    sy1_d  = 11'(py_q) + 11'(row_q);
    we_d   = v1_q && rom_q != 2'(TRANSP) && sx1_q < 11'(FB_W) && sy1_q < 11'(FB_H);
    addr_d = we_d ? 17'(sy1_q) * 17'(FB_W) + 17'(sx1_q) : addr_q;
    data_d = we_d ? rom_q : data_q;
  end
  assign rom_address = state_q == RUN ? 8'(row_q) * 8'(SPR_W) + 8'(rcol) : 8'd0;
  assign busy        = state_q == RUN || state_q == DRAIN;
  assign done        = state_q == DONE;
  assign fb_we       = we_q;
  assign fb_addr     = addr_q;
  assign fb_data     = data_q;
endmodule

// File: tb/tb_hp_sprite_blitter.sv
// tb_hp_sprite_blitter: scoreboard bench; each expected write carries its address, data and the cycle it must appear in.
module tb_hp_sprite_blitter;
  logic vga_clk = 1'b0, reset_n = 1'b0, start = 1'b0, flip_h = 1'b0;
  logic [9:0] pos_x = '0, pos_y = '0;
  logic [1:0] rom_q = '0;
  logic busy, done, fb_we;
  logic [7:0] rom_address;
  logic [16:0] fb_addr;
  logic [1:0] fb_data;
  hp_sprite_blitter dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .start(start), .pos_x(pos_x), .pos_y(pos_y),
    .flip_h(flip_h), .busy(busy), .done(done), .rom_address(rom_address), .rom_q(rom_q),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data)
  );
  always #5 vga_clk = ~vga_clk;
  typedef struct {int addr; int data; int cyc;} exp_t;
  exp_t sb[$];
  logic [1:0] rom [0:255];
  int fbmem [0:76799];
  int cyc = 0, total = 0, bad = 0, nwr = 0, non_one = 0, first_addr = -1, first_data = -1, last_addr = -1;
  always @(posedge vga_clk) cyc <= cyc + 1;
  always @(posedge vga_clk) rom_q <= rom[rom_address];
  always @(negedge vga_clk) begin
    if (fb_we === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%0d cyc=%0d, want no write", fb_addr, fb_data, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (fb_addr !== 17'(e.addr) || fb_data !== 2'(e.data) || cyc !== e.cyc) begin
          bad++;
          $display("FAIL write: got addr=%0d data=%0d cyc=%0d, want addr=%0d data=%0d cyc=%0d",
                   fb_addr, fb_data, cyc, e.addr, e.data, e.cyc);
        end
      end
      if (nwr == 0) begin
        first_addr = int'(fb_addr);
        first_data = int'(fb_data);
      end
      nwr++;
      last_addr = int'(fb_addr);
      if (fb_data != 2'd1) non_one++;
      if (fb_addr < 17'd76800) fbmem[fb_addr] = int'(fb_data);
    end
  end
  task automatic fill_rom(int mode);
    for (int w = 0; w < 256; w++)
      rom[w] = mode == 0 ? 2'((w % 3) + 1) : ((w % 12) % 2 == 0 ? 2'd0 : 2'd1);
  endtask
  task automatic clear_obs();
    sb.delete();
    nwr = 0;
    non_one = 0;
    first_addr = -1;
    first_data = -1;
    last_addr = -1;
    for (int a = 0; a < 76800; a++) fbmem[a] = -1;
  endtask
  task automatic push_blit(int x, int y, bit f, int ce);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 12; c++) begin
        int d, sx, sy;
        d  = int'(rom[r * 12 + (f ? 11 - c : c)]);
        sx = x + c;
        sy = y + r;
        if (d != 0 && sx < 320 && sy < 240) sb.push_back('{sy * 320 + sx, d, ce + r * 12 + c + 2});
      end
  endtask
  task automatic begin_blit(int x, int y, bit f, output int ce);
    @(negedge vga_clk);
    pos_x = 10'(x);
    pos_y = 10'(y);
    flip_h = f;
    start = 1'b1;
    ce = cyc + 1;
    push_blit(x, y, f, ce);
    @(negedge vga_clk);
    start = 1'b0;
  endtask
  task automatic wait_done(int ce, bit poke, string nm);
    int dc = -1, busy_err = 0;
    for (int k = 0; k < 300; k++) begin
      if (poke && cyc == ce + 20) start = 1'b1;
      if (poke && cyc == ce + 21) start = 1'b0;
      if (busy !== (cyc >= ce && cyc <= ce + 193)) busy_err++;
      if (done === 1'b1) begin
        dc = cyc;
        break;
      end
      @(negedge vga_clk);
    end
    total++;
    if (dc !== ce + 194) begin
      bad++;
      $display("FAIL %s_done_cycle: got %0d want %0d", nm, dc - ce, 194);
    end
    total++;
    if (busy_err != 0) begin
      bad++;
      $display("FAIL %s_busy: got %0d wrong cycles want 0", nm, busy_err);
    end
    @(negedge vga_clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_missing_writes: got %0d left want 0", nm, sb.size());
    end
  endtask
  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge vga_clk);
    total++;
    if ({busy, done, fb_we, rom_address, fb_addr, fb_data} !== '0) begin
      bad++;
      $display("FAIL reset_state: got busy=%b done=%b we=%b ra=%0d addr=%0d data=%0d want all 0",
               busy, done, fb_we, rom_address, fb_addr, fb_data);
    end
    reset_n = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge vga_clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_start_ignored: got busy=%b want 0", busy);
    end
  endtask
  task automatic test_basic();
    int ce;
    fill_rom(0);
    clear_obs();
    begin_blit(100, 50, 1'b0, ce);
    pos_x = 10'd7;
    pos_y = 10'd3;
    flip_h = 1'b1;
    wait_done(ce, 1'b1, "basic");
    total++;
    if (nwr != 192 || first_addr != 16100 || last_addr != 65 * 320 + 111) begin
      bad++;
      $display("FAIL basic_counts: got n=%0d first=%0d last=%0d want 192 16100 %0d", nwr, first_addr, last_addr, 65 * 320 + 111);
    end
    repeat (5) @(negedge vga_clk);
    total++;
    if (busy !== 1'b0 || rom_address !== 8'd0) begin
      bad++;
      $display("FAIL basic_no_queue: got busy=%b ra=%0d want 0 0", busy, rom_address);
    end
  endtask
  task automatic test_transparency();
    int ce;
    fill_rom(1);
    clear_obs();
    begin_blit(0, 0, 1'b0, ce);
    wait_done(ce, 1'b0, "transp");
    total++;
    if (nwr != 96 || non_one != 0 || fbmem[0] != -1) begin
      bad++;
      $display("FAIL transp: got n=%0d non1=%0d mem0=%0d want 96 0 -1", nwr, non_one, fbmem[0]);
    end
  endtask
  task automatic test_clip();
    int ce;
    fill_rom(0);
    clear_obs();
    begin_blit(315, 235, 1'b0, ce);
    wait_done(ce, 1'b0, "clip");
    total++;
    if (nwr != 25 || last_addr != 76799) begin
      bad++;
      $display("FAIL clip: got n=%0d last=%0d want 25 76799", nwr, last_addr);
    end
  endtask
  task automatic test_offscreen();
    int ce;
    fill_rom(0);
    clear_obs();
    begin_blit(320, 10, 1'b0, ce);
    wait_done(ce, 1'b0, "offscreen");
    total++;
    if (nwr != 0) begin
      bad++;
      $display("FAIL offscreen: got n=%0d want 0", nwr);
    end
  endtask
  task automatic test_flip();
    int ce;
    fill_rom(0);
    clear_obs();
    begin_blit(0, 0, 1'b1, ce);
    total++;
    if (rom_address !== 8'd11) begin
      bad++;
      $display("FAIL flip_first_rom_address: got %0d want 11", rom_address);
    end
    wait_done(ce, 1'b0, "flip");
    total++;
    if (first_addr != 0 || first_data != int'(rom[11]) || fbmem[11] != int'(rom[0])) begin
      bad++;
      $display("FAIL flip: got first=%0d/%0d mem11=%0d want 0/%0d %0d", first_addr, first_data, fbmem[11], rom[11], rom[0]);
    end
  endtask
  task automatic test_mid_reset();
    int ce, nw0, stray = 0;
    fill_rom(0);
    clear_obs();
    begin_blit(20, 30, 1'b0, ce);
    while (cyc < ce + 60) @(negedge vga_clk);
    reset_n = 1'b0;
    start = 1'b1;
    @(negedge vga_clk);
    total++;
    if (fb_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL midreset_abort: got we=%b busy=%b done=%b want 0 0 0", fb_we, busy, done);
    end
    reset_n = 1'b1;
    start = 1'b0;
    sb.delete();
    nw0 = nwr;
    repeat (20) begin
      @(negedge vga_clk);
      if (busy !== 1'b0 || done !== 1'b0) stray++;
    end
    total++;
    if (stray != 0 || nwr != nw0) begin
      bad++;
      $display("FAIL midreset_quiet: got stray=%0d writes=%0d want 0 0", stray, nwr - nw0);
    end
    clear_obs();
    begin_blit(200, 100, 1'b0, ce);
    wait_done(ce, 1'b0, "after_reset");
    total++;
    if (nwr != 192) begin
      bad++;
      $display("FAIL after_reset_count: got %0d want 192", nwr);
    end
  endtask
  task automatic test_back_to_back();
    int ce, nd = 0, d1 = -1, d2 = -1, rise2 = -1;
    logic prev_busy = 1'b0, busy_gap = 1'bx;
    fill_rom(0);
    clear_obs();
    @(negedge vga_clk);
    pos_x = 10'd40;
    pos_y = 10'd40;
    flip_h = 1'b0;
    start = 1'b1;
    ce = cyc + 1;
    push_blit(40, 40, 1'b0, ce);
    push_blit(40, 40, 1'b0, ce + 196);
    while (cyc < ce + 450) begin
      @(negedge vga_clk);
      if (cyc == ce + 300) start = 1'b0;
      if (done === 1'b1) begin
        nd++;
        if (nd == 1) d1 = cyc;
        if (nd == 2) d2 = cyc;
      end
      if (cyc == ce + 195) busy_gap = busy;
      if (busy === 1'b1 && !prev_busy && cyc > ce) rise2 = cyc;
      prev_busy = busy;
    end
    total++;
    if (nd != 2 || d1 != ce + 194 || d2 != ce + 390) begin
      bad++;
      $display("FAIL b2b_done: got n=%0d d1=%0d d2=%0d want 2 194 390", nd, d1 - ce, d2 - ce);
    end
    total++;
    if (busy_gap !== 1'b0 || rise2 != ce + 196) begin
      bad++;
      $display("FAIL b2b_restart: got gap_busy=%b rise=%0d want 0 196", busy_gap, rise2 - ce);
    end
    total++;
    if (nwr != 384 || sb.size() != 0) begin
      bad++;
      $display("FAIL b2b_writes: got n=%0d left=%0d want 384 0", nwr, sb.size());
    end
  endtask
  initial begin
    fill_rom(0);
    clear_obs();
    test_reset();
    test_basic();
    test_transparency();
    test_clip();
    test_offscreen();
    test_flip();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
